// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one ROM port between fetch (m0) and LSU (m1); m1 has priority,
// m0 is forced through after STARVE_LIMIT lost arbitrations. Perf counters: define ROM_ARB_PERF_EN.
module rom_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [3:0]        m1_sel_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [ADDR_W-1:0] mem_r_addr_o,
    output logic              mem_w_en_o,
    output logic [ADDR_W-1:0] mem_w_addr_o,
    output logic [DATA_W-1:0] mem_w_data_o,
    output logic [3:0]        mem_w_sel_o,
    input  logic [DATA_W-1:0] mem_r_data_i,
    output logic [31:0]       perf_conflict_o,
    output logic [31:0]       perf_stall_o
);

    localparam logic [CNT_W-1:0] STARVE_THR = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             m0_win;
    logic             m1_win;
    logic             m1_wr;
    logic [1:0]       rd_gnt;

    // Grants are suppressed during reset so nothing reaches the ROM or the response regs.
    always_comb begin
        m0_win = 1'b0;
        m1_win = 1'b0;
        if (!rst) begin
            if (m0_req_i && m1_req_i) begin
                if (starve_cnt_reg >= STARVE_THR) begin
                    m0_win = 1'b1;
                end else begin
                    m1_win = 1'b1;
                end
            end else begin
                m0_win = m0_req_i;
                m1_win = m1_req_i;
            end
        end
    end

    always_comb begin
        starve_cnt_next = '0;
        if (m0_req_i && !m0_win) begin
            starve_cnt_next = (starve_cnt_reg == CNT_MAX) ? starve_cnt_reg
                                                          : starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    assign m0_gnt_o     = m0_win;
    assign m1_gnt_o     = m1_win;
    assign m1_wr        = m1_win && m1_we_i;
    assign rd_gnt       = {m1_win && !m1_we_i, m0_win};
    assign mem_r_addr_o = m1_win ? m1_addr_i : m0_addr_i;
    assign mem_w_en_o   = m1_wr;
    assign mem_w_addr_o = m1_wr ? m1_addr_i  : '0;
    assign mem_w_data_o = m1_wr ? m1_wdata_i : '0;
    assign mem_w_sel_o  = m1_wr ? m1_sel_i   : 4'b0000;

    // One response channel per master: rdata holds the last word captured for that master.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            logic              rvalid_reg;
            logic [DATA_W-1:0] rdata_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= rd_gnt[gi];
                    if (rd_gnt[gi]) begin
                        rdata_reg <= mem_r_data_i;
                    end
                end
            end
        end
    endgenerate

    assign m0_rvalid_o = g_resp[0].rvalid_reg;
    assign m0_rdata_o  = g_resp[0].rdata_reg;
    assign m1_rvalid_o = g_resp[1].rvalid_reg;
    assign m1_rdata_o  = g_resp[1].rdata_reg;

`ifdef ROM_ARB_PERF_EN
    logic [31:0] perf_conflict_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_reg <= '0;
            perf_stall_reg    <= '0;
        end else begin
            if (m0_req_i && m1_req_i) begin
                perf_conflict_reg <= perf_conflict_reg + 32'd1;
            end
            if (m0_req_i && !m0_win) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_conflict_o = perf_conflict_reg;
    assign perf_stall_o    = perf_stall_reg;
`else
    assign perf_conflict_o = 32'h0;
    assign perf_stall_o    = 32'h0;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed vector table, hand sequences, and randomized traffic
// checked against a cycle-level reference model with its own copy of the ROM contents.
module tb_rom_port_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 3;
`ifdef ROM_ARB_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        m0_req;
        logic [31:0] m0_addr;
        logic        m1_req;
        logic        m1_we;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic [3:0]  m1_sel;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rv;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic        exp_wen;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic              m0_gnt_o;
    logic              m0_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m1_req_i;
    logic              m1_we_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic [3:0]        m1_sel_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [DATA_W-1:0] m1_rdata_o;
    logic [ADDR_W-1:0] mem_r_addr_o;
    logic              mem_w_en_o;
    logic [ADDR_W-1:0] mem_w_addr_o;
    logic [DATA_W-1:0] mem_w_data_o;
    logic [3:0]        mem_w_sel_o;
    logic [DATA_W-1:0] mem_r_data_i;
    logic [31:0]       perf_conflict_o;
    logic [31:0]       perf_stall_o;

    always #5 clk = ~clk;

    rom_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_r_addr_o(mem_r_addr_o), .mem_w_en_o(mem_w_en_o), .mem_w_addr_o(mem_w_addr_o),
        .mem_w_data_o(mem_w_data_o), .mem_w_sel_o(mem_w_sel_o), .mem_r_data_i(mem_r_data_i),
        .perf_conflict_o(perf_conflict_o), .perf_stall_o(perf_stall_o)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'hAABBCCDD;
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // ROM attached to the DUT: combinational read, byte-masked write on posedge.
    logic [31:0] rom_mem [256];
    assign mem_r_data_i = rom_mem[mem_r_addr_o[9:2]];
    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_w_en_o)
                rom_mem[mem_w_addr_o[9:2]] <= merge(rom_mem[mem_w_addr_o[9:2]], mem_w_data_o,
                                                    mem_w_sel_o);
        end
    end

    // Reference model state: what the outputs must show in the current cycle.
    logic [31:0] ref_mem [256];
    logic        m_rv0, m_rv1;
    logic [31:0] m_rd0, m_rd1;
    int          m_streak;
    logic [31:0] m_conf, m_stall;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.m0_req = 1'b0; s.m0_addr = 32'h0; s.m1_req = 1'b0; s.m1_we = 1'b0;
        s.m1_addr = 32'h0; s.m1_wdata = 32'h0; s.m1_sel = 4'h0;
        return s;
    endfunction

    function automatic stim_t mks(input logic r, input logic q0, input logic [31:0] a0,
                                  input logic q1, input logic we, input logic [31:0] a1,
                                  input logic [31:0] wd, input logic [3:0] sel);
        stim_t s;
        s.rst = r; s.m0_req = q0; s.m0_addr = a0; s.m1_req = q1; s.m1_we = we;
        s.m1_addr = a1; s.m1_wdata = wd; s.m1_sel = sel;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic [1:0] g, input logic [1:0] rv,
                                 input logic [31:0] rd0, input logic [31:0] rd1, input logic wen);
        vec_t v;
        v.s = s; v.exp_gnt = g; v.exp_rv = rv; v.exp_rd0 = rd0; v.exp_rd1 = rd1; v.exp_wen = wen;
        return v;
    endfunction

    // One clock cycle: apply stimulus, check every output against the model, advance the model.
    task automatic step(input stim_t s, output int win);
        logic        e_wen;
        logic [31:0] e_raddr;
        @(posedge clk);
        #1;
        cyc++;
        rst = s.rst; m0_req_i = s.m0_req; m0_addr_i = s.m0_addr; m1_req_i = s.m1_req;
        m1_we_i = s.m1_we; m1_addr_i = s.m1_addr; m1_wdata_i = s.m1_wdata; m1_sel_i = s.m1_sel;
        if (s.rst) win = -1;
        else if (s.m0_req && s.m1_req) win = (m_streak >= STARVE_LIMIT) ? 0 : 1;
        else if (s.m1_req) win = 1;
        else if (s.m0_req) win = 0;
        else win = -1;
        e_wen   = (win == 1) && s.m1_we;
        e_raddr = (win == 1) ? s.m1_addr : s.m0_addr;
        @(negedge clk);
        $display("cyc %0d rst=%0b req=%0b%0b we=%0b gnt=%0b%0b rv=%0b%0b rd0=%h rd1=%h",
                 cyc, s.rst, s.m1_req, s.m0_req, s.m1_we, m1_gnt_o, m0_gnt_o,
                 m1_rvalid_o, m0_rvalid_o, m0_rdata_o, m1_rdata_o);
        chk("m0_gnt", 32'(m0_gnt_o), 32'(win == 0));
        chk("m1_gnt", 32'(m1_gnt_o), 32'(win == 1));
        chk("m0_rvalid", 32'(m0_rvalid_o), 32'(m_rv0));
        chk("m1_rvalid", 32'(m1_rvalid_o), 32'(m_rv1));
        chk("m0_rdata", m0_rdata_o, m_rd0);
        chk("m1_rdata", m1_rdata_o, m_rd1);
        chk("mem_r_addr", mem_r_addr_o, e_raddr);
        chk("mem_w_en", 32'(mem_w_en_o), 32'(e_wen));
        chk("mem_w_addr", mem_w_addr_o, e_wen ? s.m1_addr : 32'h0);
        chk("mem_w_data", mem_w_data_o, e_wen ? s.m1_wdata : 32'h0);
        chk("mem_w_sel", 32'(mem_w_sel_o), e_wen ? 32'(s.m1_sel) : 32'h0);
        chk("perf_conflict", perf_conflict_o, PERF_EN ? m_conf : 32'h0);
        chk("perf_stall", perf_stall_o, PERF_EN ? m_stall : 32'h0);
        if (s.rst) begin
            m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = 32'h0; m_rd1 = 32'h0;
            m_streak = 0; m_conf = 32'h0; m_stall = 32'h0;
        end else begin
            m_rv0 = (win == 0);
            m_rv1 = (win == 1) && !s.m1_we;
            if (win == 0) m_rd0 = ref_mem[s.m0_addr[9:2]];
            if (m_rv1) m_rd1 = ref_mem[s.m1_addr[9:2]];
            if (e_wen) ref_mem[s.m1_addr[9:2]] = merge(ref_mem[s.m1_addr[9:2]], s.m1_wdata, s.m1_sel);
            if (s.m0_req && win != 0) begin
                if (m_streak < (1 << CNT_W) - 1) m_streak++;
                m_stall = m_stall + 32'd1;
            end else begin
                m_streak = 0;
            end
            if (s.m0_req && s.m1_req) m_conf = m_conf + 32'd1;
        end
    endtask

    initial begin
        vec_t  vecs[$];
        stim_t s, both, rd0, rd1;
        int    w;
        logic  hold0, hold1;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = 32'h0; m_rd1 = 32'h0;
        m_streak = 0; m_conf = 32'h0; m_stall = 32'h0;
        s = idle();
        rst = 1'b1; m0_req_i = 1'b0; m0_addr_i = '0; m1_req_i = 1'b0; m1_we_i = 1'b0;
        m1_addr_i = '0; m1_wdata_i = '0; m1_sel_i = 4'h0;
        @(posedge clk);

        both = mks(0, 1, 32'h10, 1, 0, 32'h20, 32'h0, 4'h0);
        rd0  = mks(0, 1, 32'h10, 0, 0, 32'h0, 32'h0, 4'h0);
        rd1  = mks(0, 0, 32'h0, 1, 0, 32'h20, 32'h0, 4'h0);
        // reset with both requesting: no grants, cleared outputs
        vecs.push_back(mkv(mks(1, 1, 32'h10, 1, 0, 32'h20, 0, 0), 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mkv(mks(1, 1, 32'h10, 1, 0, 32'h20, 0, 0), 2'b00, 2'b00, 0, 0, 0));
        // m0 read 0x10, data the following cycle
        vecs.push_back(mkv(rd0, 2'b01, 2'b00, 0, 0, 0));
        vecs.push_back(mkv(idle(), 2'b00, 2'b01, 32'hDEADBEEF, 0, 0));
        // m1 partial write then read of the same word
        vecs.push_back(mkv(mks(0, 0, 0, 1, 1, 32'h20, 32'h11223344, 4'b0011), 2'b10, 2'b00,
                           32'hDEADBEEF, 0, 1));
        vecs.push_back(mkv(rd1, 2'b10, 2'b00, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mkv(idle(), 2'b00, 2'b10, 32'hDEADBEEF, 32'hAABB3344, 0));
        vecs.push_back(mkv(both, 2'b10, 2'b00, 32'hDEADBEEF, 32'hAABB3344, 0));
        vecs.push_back(mkv(both, 2'b10, 2'b10, 32'hDEADBEEF, 32'hAABB3344, 0));
        // reset with a response pending: visible now, discarded at the edge
        vecs.push_back(mkv(mks(1, 1, 32'h10, 0, 0, 0, 0, 0), 2'b00, 2'b10,
                           32'hDEADBEEF, 32'hAABB3344, 0));
        vecs.push_back(mkv(idle(), 2'b00, 2'b00, 0, 0, 0));
        // sustained contention: m1 x4, m0 x1, repeated
        for (int k = 0; k < 10; k++) begin
            vecs.push_back(mkv(both, (k == 4 || k == 9) ? 2'b01 : 2'b10,
                               (k == 0) ? 2'b00 : ((k == 5) ? 2'b01 : 2'b10),
                               (k >= 5) ? 32'hDEADBEEF : 32'h0,
                               (k >= 1) ? 32'hAABB3344 : 32'h0, 0));
        end
        vecs.push_back(mkv(idle(), 2'b00, 2'b01, 32'hDEADBEEF, 32'hAABB3344, 0));

        foreach (vecs[i]) begin
            step(vecs[i].s, w);
            chk("tbl_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'(vecs[i].exp_gnt));
            chk("tbl_rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), 32'(vecs[i].exp_rv));
            chk("tbl_rdata0", m0_rdata_o, vecs[i].exp_rd0);
            chk("tbl_rdata1", m1_rdata_o, vecs[i].exp_rd1);
            chk("tbl_w_en", 32'(mem_w_en_o), 32'(vecs[i].exp_wen));
        end
        chk("tbl_w_sel_seen", 32'(rom_mem[8]), 32'hAABB3344);
        chk("tbl_perf_conflict", perf_conflict_o, PERF_EN ? 32'd10 : 32'd0);
        chk("tbl_perf_stall", perf_stall_o, PERF_EN ? 32'd8 : 32'd0);

        // reset landing on an m1 read request after m0 has built up a starvation count
        step(both, w);
        step(both, w);
        step(mks(1, 1, 32'h10, 1, 0, 32'h20, 0, 0), w);
        chk("rst_m1_gnt", 32'(m1_gnt_o), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(both, w);
            if (k == 0) chk("rst_no_m1_rvalid", 32'(m1_rvalid_o), 32'h0);
            chk("rst_starve_cleared", 32'(m0_gnt_o), 32'(k == 4));
        end

        // randomized traffic; an ungranted requester holds its request
        hold0 = 1'b0; hold1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!hold0) begin
                s.m0_req  = ($urandom_range(0, 3) != 0);
                s.m0_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!hold1) begin
                s.m1_req   = ($urandom_range(0, 2) != 0);
                s.m1_we    = ($urandom_range(0, 2) == 0);
                s.m1_addr  = 32'($urandom_range(0, 15)) << 2;
                s.m1_wdata = $urandom;
                s.m1_sel   = 4'($urandom_range(0, 15));
            end
            s.rst = ($urandom_range(0, 59) == 0);
            step(s, w);
            hold0 = s.m0_req && (w != 0);
            hold1 = s.m1_req && (w != 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
